// File: rtl/result_serializer_pkg.sv
// Shared encodings for the result serializer: global processing states,
// serializer FSM states and sync header bytes.
package result_serializer_pkg;

   localparam logic [2:0] GS_IDLE         = 3'd0;
   localparam logic [2:0] GS_CAPTURE      = 3'd1;
   localparam logic [2:0] THRESHOLD_STATE = 3'd2;
   localparam logic [2:0] SERIALIZE_STATE = 3'd3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      READ = 3'd3,
      SEND = 3'd4,
      DONE = 3'd5
   } ser_state_e;

   localparam logic [7:0] SYNC0 = 8'h55;
   localparam logic [7:0] SYNC1 = 8'hAA;

endpackage

// File: rtl/result_serializer_bit_packer_8.sv
// MSB-first bit packer: shifts a pixel in at the LSB on each enable and flags
// the eighth shift, presenting the completed byte in that same cycle.
module bit_packer_8 (
   input  logic       clock,
   input  logic       reset,
   input  logic       shift_en_i,
   input  logic       bit_i,
   output logic [7:0] byte_o,
   output logic [2:0] count_o,
   output logic       byte_ready_o
);

   // The eighth bit goes straight into the caller's output register, so seven bits of history suffice.
   logic [6:0] shift_q, shift_d;
   logic [2:0] count_q, count_d;

   // Next-state for shift history and bit counter.
   always_comb begin
      shift_d = shift_q;
      count_d = count_q;
      if (shift_en_i) begin
         shift_d = {shift_q[5:0], bit_i};
         count_d = count_q + 3'd1;
      end else begin
         shift_d = shift_q;
         count_d = count_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q <= 7'd0;
         count_q <= 3'd0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   assign byte_o       = {shift_q, bit_i};
   assign count_o      = count_q;
   assign byte_ready_o = shift_en_i && (count_q == 3'd7);

endmodule

// File: rtl/result_serializer.sv
// Streams the binary result memory out as MSB-first packed bytes over valid/ready.
// Optional sync header (0x55, 0xAA) enabled by RESULT_SERIALIZER_SYNC_HEADER_EN.
module result_serializer
   import result_serializer_pkg::*;
#(
   parameter int         WIDTH_BITS   = 8,
   parameter int         HEIGHT_BITS  = 8,
   parameter logic [2:0] ACTIVE_STATE = SERIALIZE_STATE
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic [WIDTH_BITS-1:0]  oResultCol,
   output logic [HEIGHT_BITS-1:0] oResultRow,
   input  logic                   iResultData,
   input  logic [2:0]             global_state,
   output logic [7:0]             oTxData,
   output logic                   oTxValid,
   input  logic                   iTxReady,
   output logic                   finished
);

   localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;
   localparam logic [POS_BITS-1:0] LAST_POS = '1;

   ser_state_e          state_q, state_d;
   logic [POS_BITS-1:0] pos_q, pos_d;
   logic                pend_q, pend_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                finished_q, finished_d;

   logic       active_s;
   logic       accept_s;
   logic       shift_en_s;
   logic [7:0] pk_byte_s;
   logic [2:0] pk_count_s;
   logic       pk_ready_s;

   assign active_s   = (global_state == ACTIVE_STATE);
   assign accept_s   = tx_valid_q && iTxReady;
   // pend_q marks that the address issued last cycle has its data on iResultData now.
   assign shift_en_s = (state_q == READ) && active_s && pend_q;

   bit_packer_8 u_packer (
      .clock        (clock),
      .reset        (reset),
      .shift_en_i   (shift_en_s),
      .bit_i        (iResultData),
      .byte_o       (pk_byte_s),
      .count_o      (pk_count_s),
      .byte_ready_o (pk_ready_s)
   );

   // FSM next-state, address generation and transmit register updates.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      pend_d     = pend_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      finished_d = finished_q;
      case (state_q)
         IDLE: begin
            if (active_s && !finished_q) begin
`ifdef RESULT_SERIALIZER_SYNC_HEADER_EN
               state_d    = HDR0;
               tx_data_d  = SYNC0;
               tx_valid_d = 1'b1;
`else
               // The start cycle already issues pixel 0, giving 9 cycles to the first valid byte.
               state_d = READ;
               pend_d  = 1'b1;
               pos_d   = pos_q + {{(POS_BITS-1){1'b0}}, 1'b1};
`endif
            end else begin
               state_d = IDLE;
            end
         end
`ifdef RESULT_SERIALIZER_SYNC_HEADER_EN
         HDR0: begin
            if (accept_s) begin
               state_d   = HDR1;
               tx_data_d = SYNC1;
            end else begin
               state_d = HDR0;
            end
         end
         HDR1: begin
            if (accept_s) begin
               state_d    = READ;
               tx_valid_d = 1'b0;
            end else begin
               state_d = HDR1;
            end
         end
`endif
         READ: begin
            if (!active_s) begin
               // Any in-flight read is dropped; rewind to the pending bit so it is re-issued on resume.
               pend_d = 1'b0;
               pos_d  = {pos_q[POS_BITS-1:3], pk_count_s};
            end else if (pk_ready_s) begin
               state_d    = SEND;
               pend_d     = 1'b0;
               tx_data_d  = pk_byte_s;
               tx_valid_d = 1'b1;
            end else begin
               pend_d = 1'b1;
               if (pos_q[2:0] != 3'd7) begin
                  pos_d = pos_q + {{(POS_BITS-1){1'b0}}, 1'b1};
               end else begin
                  pos_d = pos_q;
               end
            end
         end
         SEND: begin
            if (accept_s) begin
               tx_valid_d = 1'b0;
               if (pos_q == LAST_POS) begin
                  state_d    = DONE;
                  pos_d      = '0;
                  finished_d = 1'b1;
               end else begin
                  state_d = READ;
                  pos_d   = pos_q + {{(POS_BITS-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = SEND;
            end
         end
         DONE: begin
            state_d    = DONE;
            pos_d      = '0;
            tx_valid_d = 1'b0;
            finished_d = 1'b1;
         end
         default: begin
            state_d    = IDLE;
            pos_d      = '0;
            pend_d     = 1'b0;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pos_q      <= '0;
         pend_q     <= 1'b0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         pend_q     <= pend_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         finished_q <= finished_d;
      end
   end

   assign oResultRow = pos_q[POS_BITS-1:WIDTH_BITS];
   assign oResultCol = pos_q[WIDTH_BITS-1:0];
   assign oTxData    = tx_data_q;
   assign oTxValid   = tx_valid_q;
   assign finished   = finished_q;

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer on a 16x16 frame with a queue-based
// reference model of the byte stream.
module tb_result_serializer;
   import result_serializer_pkg::*;

   localparam int WB     = 4;
   localparam int HB     = 4;
   localparam int NPIX   = 256;
   localparam int NBYTES = 32;
`ifdef RESULT_SERIALIZER_SYNC_HEADER_EN
   localparam int HDR_N = 2;
`else
   localparam int HDR_N = 0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [WB-1:0] col;
   logic [HB-1:0] row;
   logic          rdata = 1'b0;
   logic [2:0]    gs = 3'd0;
   logic [7:0]    txd;
   logic          txv;
   logic          rdy = 1'b0;
   logic          fin;

   logic       mem [NPIX];
   logic [7:0] expq [$];
   logic [7:0] acc_log [1024];
   int         acc_total = 0;
   int         checks = 0;
   int         failures = 0;
   logic       rand_rdy = 1'b0;

   result_serializer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .ACTIVE_STATE(3'd3)) dut (
      .clock(clock), .reset(reset), .oResultCol(col), .oResultRow(row),
      .iResultData(rdata), .global_state(gs), .oTxData(txd), .oTxValid(txv),
      .iTxReady(rdy), .finished(fin)
   );

   always #5 clock = ~clock;

   // Synchronous result memory: data follows the address by one cycle.
   always @(posedge clock) rdata <= mem[{row, col}];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   // Expected frame: optional sync bytes, then pixel 8b+i lands in bit 7-i of byte b.
   task automatic build_frame();
      logic [7:0] v;
      expq.delete();
      if (HDR_N == 2) begin
         expq.push_back(8'h55);
         expq.push_back(8'hAA);
      end
      for (int b = 0; b < NBYTES; b++) begin
         v = 8'd0;
         for (int i = 0; i < 8; i++) v = v | (8'(mem[8*b+i]) << (7 - i));
         expq.push_back(v);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (rand_rdy) rdy = ($urandom_range(0, 99) < 60);
   endtask

   task automatic wait_fin(input string name);
      int n = 0;
      while (!fin && n < 3000) begin
         step();
         n++;
      end
      if (!fin) timeout_fail(name);
   endtask

   task automatic wait_acc(input string name, input int target);
      int n = 0;
      while (acc_total < target && n < 1000) begin
         step();
         n++;
      end
      if (acc_total < target) timeout_fail(name);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!txv && n < 100) begin
         step();
         n++;
      end
      if (!txv) timeout_fail(name);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      gs = 3'd0;
      rdy = 1'b0;
      rand_rdy = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Compare process: byte stream, hold-while-stalled and finished timing.
   initial begin
      logic pv = 1'b0, pr = 1'b0, pacc = 1'b0, pfin = 1'b0;
      logic [7:0] pd = 8'd0;
      logic [7:0] pa = 8'd0;
      forever begin
         @(negedge clock);
         if (reset) begin
            pv = 1'b0; pr = 1'b0; pacc = 1'b0; pfin = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("hold_valid", int'(txv), 1);
               chk("hold_data", int'(txd), int'(pd));
               chk("hold_addr", int'({row, col}), int'(pa));
            end
            if (fin && !pfin) begin
               chk("fin_one_after_last_accept", int'(pacc), 1);
               chk("fin_all_sent", expq.size(), 0);
            end
            if (fin) chk("no_valid_when_done", int'(txv), 0);
            if (txv && rdy) begin
               acc_log[acc_total] = txd;
               acc_total++;
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL extra_byte actual=0x%0h expected=none", txd);
               end else begin
                  chk("byte", int'(txd), int'(expq.pop_front()));
               end
            end
            pv = txv; pr = rdy; pd = txd; pa = {row, col}; pacc = txv && rdy; pfin = fin;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int lat;
      int k;
      logic [7:0] e0;
      for (int i = 0; i < NPIX; i++) mem[i] = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", int'(txv), 0);
      chk("rst_data", int'(txd), 0);
      chk("rst_finished", int'(fin), 0);
      chk("rst_row", int'(row), 0);
      chk("rst_col", int'(col), 0);
      reset = 1'b0;

      // Frame A: all-white image, ready tied high.
      build_frame();
      chk("model_all_ones", int'(expq[HDR_N]), 8'hFF);
      base = acc_total;
      rdy = 1'b1;
      gs = 3'd3;
      wait_fin("frameA_finish");
      chk("frameA_count", acc_total - base, NBYTES + HDR_N);
      chk("frameA_first_data", int'(acc_log[base + HDR_N]), 8'hFF);
      repeat (5) step();
      chk("finished_sticky", int'(fin), 1);

      // Frame B: random image with first pixels 1,0,0,0,0,0,0,1; stalls and pauses.
      do_reset();
      for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) mem[i] = (i == 0 || i == 7);
      build_frame();
      chk("model_0x81", int'(expq[HDR_N]), 8'h81);
      base = acc_total;
      rdy = 1'b1;
      gs = 3'd3;
      lat = 0;
      while (!txv && lat < 50) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk("first_valid_latency", lat, (HDR_N == 2) ? 1 : 9);
      rand_rdy = 1'b1;
      wait_acc("frameB_two_bytes", base + HDR_N + 2);

      rand_rdy = 1'b0;
      rdy = 1'b0;
      wait_valid("stall_valid");
      k = acc_total - base - HDR_N;
      repeat (20) step();
      rdy = 1'b1;
      step();
      chk("stall_accept_drops_valid", int'(txv), 0);
      chk("next_byte_addr0", int'({row, col}), 8 * (k + 1));
      step();
      chk("next_byte_addr1", int'({row, col}), 8 * (k + 1) + 1);

      repeat (3) step();
      gs = 3'd2;
      repeat (6) step();
      chk("paused_read_no_valid", int'(txv), 0);
      gs = 3'd3;

      wait_valid("send_pause_valid");
      gs = 3'd2;
      k = acc_total;
      step();
      repeat (5) step();
      chk("accepted_while_paused", acc_total - k, 1);
      chk("wait_after_accept_paused", int'(txv), 0);
      gs = 3'd3;
      rand_rdy = 1'b1;
      wait_fin("frameB_finish");
      chk("frameB_count", acc_total - base, NBYTES + HDR_N);
      chk("frameB_first_data", int'(acc_log[base + HDR_N]), 8'h81);

      // Frame C: reset during byte 5, then a full restart from byte 0.
      do_reset();
      for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom_range(0, 1));
      build_frame();
      e0 = expq[HDR_N];
      base = acc_total;
      rdy = 1'b1;
      gs = 3'd3;
      wait_acc("frameC_five_bytes", base + HDR_N + 5);
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", int'(txv), 0);
      chk("async_rst_data", int'(txd), 0);
      chk("async_rst_finished", int'(fin), 0);
      chk("async_rst_addr", int'({row, col}), 0);
      build_frame();
      @(posedge clock);
      #1;
      base = acc_total;
      reset = 1'b0;
      rand_rdy = 1'b1;
      wait_fin("frameD_finish");
      chk("frameD_count", acc_total - base, NBYTES + HDR_N);
      chk("frameD_first_data", int'(acc_log[base + HDR_N]), int'(e0));
      if (HDR_N == 2) begin
         chk("frameD_sync0", int'(acc_log[base]), 8'h55);
         chk("frameD_sync1", int'(acc_log[base + 1]), 8'hAA);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Reader side of the binary result memory that the thresholding stage fills.
- Runs after thresholding completes. Scans the result memory in raster order and packs 8 pixels per byte.
- Streams the bytes out over a valid/ready byte interface toward the UART/host transmitter.
- Raises `finished` once the whole frame has been handed off.

Parameters:
- WIDTH_BITS, 8, column address width
- HEIGHT_BITS, 8, row address width
- WIDTH, 2**WIDTH_BITS, image width in pixels; must be a multiple of 8
- HEIGHT, 2**HEIGHT_BITS, image height in pixels
- ACTIVE_STATE, 3, value of global_state in which this block runs

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- oResultCol  out  WIDTH_BITS  result memory read X address
- oResultRow  out  HEIGHT_BITS  result memory read Y address
- iResultData  in  1  result memory read data; valid one cycle after the address (1 = white)
- global_state  in  3  top-level processing state
- oTxData  out  8  packed pixel byte
- oTxValid  out  1  oTxData is valid
- iTxReady  in  1  downstream accepts the byte this cycle
- finished  out  1  frame fully sent; sticky until reset

Behaviour:
- Reset (async, active-high):
  - State = IDLE; pixel pointer pos = 0; bit counter = 0; shift register = 0.
  - oTxData = 0, oTxValid = 0, finished = 0.
  - Address outputs show pos, i.e. 0.
- Addressing:
  - {oResultRow, oResultCol} = pos, with row in the upper bits.
  - pos runs 0 .. WIDTH*HEIGHT-1 and is (WIDTH_BITS+HEIGHT_BITS) bits wide.
- IDLE:
  - Enter READ when global_state == ACTIVE_STATE and finished == 0. Otherwise stay.
- READ (8 issue cycles plus 1 drain cycle per byte):
  - Issue cycles: pos is presented and incremented each cycle for 8 cycles.
  - Capture: one cycle after each issue, iResultData is shifted in at the LSB of the shift register. The first pixel of a byte therefore ends in bit 7 (MSB-first).
  - On the 8th capture, load oTxData with the assembled byte, set oTxValid = 1, and go to SEND.
  - Latency: 9 cycles from READ entry to oTxValid rising.
  - pos is not incremented past the 8th address of a byte. The wrap of pos from WIDTH*HEIGHT-1 to 0 occurs only together with the final byte.
- SEND:
  - oTxData and oTxValid are held stable until the cycle where oTxValid && iTxReady.
  - In that accept cycle, deassert oTxValid.
  - If the accepted byte was the last (WIDTH*HEIGHT/8 bytes total), go to DONE. Otherwise go to READ.
  - iTxReady while oTxValid == 0 has no effect.
- DONE:
  - finished = 1, oTxValid = 0, pos = 0. Hold until reset.
- global_state != ACTIVE_STATE while in READ:
  - Pause: pos, bit counter and shift register freeze.
  - On resume, re-issue the address of the pending bit. The read is side-effect free.
- global_state != ACTIVE_STATE while in SEND:
  - A byte already asserted stays asserted and may still be accepted.
  - After acceptance, wait in READ (paused) until global_state returns to ACTIVE_STATE.
- Reset mid-frame: immediate return to reset values. Partial bytes are discarded and nothing is re-sent.
- The block never writes memory and never drives oTxValid outside SEND.

Optional Feature:
- Macro: RESULT_SERIALIZER_SYNC_HEADER_EN.
- Defined:
  - IDLE goes to HDR0, then HDR1, then READ.
  - HDR0 presents 0x55 with oTxValid = 1 and holds it until accepted. HDR1 does the same with 0xAA.
  - Pause rules are the same as for SEND.
  - The frame is WIDTH*HEIGHT/8 + 2 bytes.
- Undefined: IDLE goes directly to READ, and no header bytes exist.

Decomposition:
- Shared package holds:
  - global_state encodings (including THRESHOLD_STATE = 2 and SERIALIZE_STATE = 3)
  - state enum: IDLE, HDR0, HDR1, READ, SEND, DONE
  - header constants: SYNC0 = 8'h55, SYNC1 = 8'hAA
- One natural sub-module, `bit_packer_8`: a shift register plus 3-bit counter with a shift-enable input and a byte_ready output. The FSM and address generation stay in the top module.

Test Plan:
1. WIDTH_BITS = 4, HEIGHT_BITS = 4, memory all 1, iTxReady tied 1, state = 3 → exactly 32 bytes of 0xFF; finished rises one cycle after the 32nd accept.
2. First 8 pixels = 1,0,0,0,0,0,0,1 → first byte 0x81, with oTxValid high exactly 9 cycles after global_state becomes 3.
3. iTxReady held 0 for 20 cycles while oTxValid = 1 → oTxData stable and pos unchanged; byte accepted on the first ready cycle; next byte's addresses begin the following cycle.
4. global_state drops to 2 after 4 captures, then returns to 3 → resulting byte identical to an uninterrupted run; no address is skipped.
5. reset asserted mid-byte at byte 5 → all outputs 0 asynchronously; the next run restarts at address 0 and sends byte 0 first.
6. With RESULT_SERIALIZER_SYNC_HEADER_EN defined → first two accepted bytes are 0x55 then 0xAA, followed by 32 data bytes; without it, the first byte is data.
